sdram_byte_bridge: RTL and testbench
====================================

// Module: sdram_byte_bridge
// PURPOSE
//   Upstream stage of sdram_block: converts processor byte accesses into 16-bit word requests on the ram_* port.
//   Holds one-word read buffer (hit = 1-cycle read); byte writes done read-modify-write, write-through.
//   Enforces write->read gap (separate wr/rd FIFOs may reorder); drains stale read data after timeout.
// PARAMETERS
//   ADDR_W   24   SDRAM word-address width (cpu byte address is ADDR_W+1 bits)
//   WR_GAP   16   cycles after a write during which no SDRAM read is issued
//   TIMEOUT  255  max cycles waiting for ram_rd_ready before error completion
// PORTS
//   clk           in   1         single clock (processor clock domain)
//   rst           in   1         asynchronous, active-low reset
//   cpu_req       in   1         access request, sampled only when cpu_busy=0
//   cpu_we        in   1         1=write byte, 0=read byte
//   cpu_addr      in   ADDR_W+1  byte address; bit0=0 selects word[7:0], bit0=1 word[15:8]
//   cpu_wdata     in   8         write byte
//   cpu_rdata     out  8         read byte, valid in cpu_ack cycle
//   cpu_ack       out  1         1-cycle completion pulse
//   cpu_err       out  1         with cpu_ack: read timed out, cpu_rdata=0
//   cpu_busy      out  1         high when not IDLE or stale drain pending
//   ram_addr      out  ADDR_W    word address, registered, held through request
//   ram_wr_data   out  16        write word, registered
//   ram_wr_en     out  1         1-cycle push to write FIFO, only when ram_busy=0
//   ram_rd_en     out  1         1-cycle push to read-address FIFO, only when ram_busy=0
//   ram_rd_data   in   16        read word, valid while ram_rd_ready=1 (show-ahead FIFO)
//   ram_busy      in   1         request FIFOs full
//   ram_rd_ready  in   1         read-data FIFO non-empty
//   ram_rd_ack    out  1         1-cycle pop of read-data FIFO
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, buffer invalid, gap/timeout/stale counters 0.
//   All outputs registered. States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
//   IDLE, stale>0: cpu_busy=1, no accept; each cycle with ram_rd_ready: ram_rd_ack=1, data discarded, stale--.
//   IDLE, cpu_req, stale=0:
//     read hit (valid && tag==cpu_addr[ADDR_W:1]): next cycle cpu_ack=1, cpu_rdata=byte; stay IDLE.
//     read miss -> RD_ISSUE. write hit: merge byte into buffer -> WR_ISSUE.
//     write miss: latch byte, set rmw flag -> RD_ISSUE.
//   RD_ISSUE: wait ram_busy=0 && gap=0; then ram_rd_en=1, ram_addr=word addr, clear timeout -> RD_WAIT.
//   RD_WAIT: ram_rd_ready=1 -> capture ram_rd_data, ram_rd_ack=1, buffer valid/tag set;
//     rmw: merge latched byte -> WR_ISSUE; else cpu_ack, cpu_rdata -> IDLE.
//     timeout reaches TIMEOUT first: cpu_ack+cpu_err, buffer invalid, stale++ (saturate 3), rmw dropped -> IDLE.
//   WR_ISSUE: wait ram_busy=0; ram_wr_en=1, ram_wr_data=buffer; gap<=WR_GAP; cpu_ack -> IDLE.
//   gap decrements every cycle to 0, independent of state.
//   Latency: hit read 1 cycle; write hit 2 cycles min; miss = issue + SDRAM round trip + 1.
//   cpu_req while busy: ignored (not queued). Same-cycle ready and timeout: data wins.
//   Reset mid-operation: immediate return to reset values; sdram_block FIFOs are reset by the same rst.
// STRUCTURE
//   Package sdram_pkg: state enum typedef, byte-lane select constants, default WR_GAP/TIMEOUT.
//   No sub-module; buffer, FSM and counters in one module.
// TESTING
//   Read 0x000011 with SDRAM word 0x3C5A at 0x000008 -> one ram_rd_en addr 0x000008, cpu_rdata=0x3C, ram_rd_ack 1 cycle.
//   Then read 0x000010 -> no ram_rd_en, cpu_ack next cycle, cpu_rdata=0x5A.
//   Write 0xEE to 0x000021 (miss, word 0x1234) -> rd then ram_wr_en with ram_wr_data=0xEE34; next read waits >=16 cycles.
//   ram_busy held 10 cycles during RD_ISSUE -> ram_rd_en only after release, exactly one pulse.
//   No ram_rd_ready for 255 cycles -> cpu_ack+cpu_err; late word popped and discarded; next read returns correct data.
//   Assert rst low in RD_WAIT -> all outputs 0 same cycle, buffer invalid, next read is miss.

Source files
------------

// File: rtl/sdram_byte_bridge_pkg.sv
// rtl/sdram_byte_bridge_pkg.sv - shared types, byte-lane helpers and defaults for the byte bridge
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE
    } state_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam int DEFAULT_WR_GAP  = 16;
    localparam int DEFAULT_TIMEOUT = 255;

    function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic [7:0] b,
                                               input logic lane);
        return (lane == LANE_HI) ? {b, word[7:0]} : {word[15:8], b};
    endfunction

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sdram_byte_bridge_if.sv
// rtl/sdram_byte_bridge_if.sv - cpu byte port and sdram word port bundle
interface sdram_byte_bridge_if #(parameter int ADDR_W = 24);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W:0]   cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              cpu_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wr_data;
    logic              ram_wr_en;
    logic              ram_rd_en;
    logic [15:0]       ram_rd_data;
    logic              ram_busy;
    logic              ram_rd_ready;
    logic              ram_rd_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rd_data, ram_busy, ram_rd_ready,
        input  cpu_rdata, cpu_ack, cpu_err, cpu_busy, ram_addr, ram_wr_data, ram_wr_en,
               ram_rd_en, ram_rd_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rd_data, ram_busy, ram_rd_ready,
        output cpu_rdata, cpu_ack, cpu_err, cpu_busy, ram_addr, ram_wr_data, ram_wr_en,
               ram_rd_en, ram_rd_ack
    );

endinterface

// File: rtl/sdram_byte_bridge.sv
// rtl/sdram_byte_bridge.sv - cpu byte accesses to 16-bit sdram words with a one-word write-through buffer
module sdram_byte_bridge
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int WR_GAP  = DEFAULT_WR_GAP,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    sdram_byte_bridge_if.slave bus
);

    localparam int GAP_W = $clog2(WR_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t            state;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [15:0]       buf_data;
    logic              rmw;
    logic              req_lane;
    logic [7:0]        req_byte;
    logic [GAP_W-1:0]  gap;
    logic [TO_W-1:0]   tmo;
    logic [1:0]        stale;

    logic [ADDR_W-1:0] cpu_word;
    logic              hit;
    logic              rd_take;

    assign cpu_word = bus.cpu_addr[ADDR_W:1];
    assign hit      = buf_valid && (buf_tag == cpu_word);
    // The read-data FIFO still shows the popped word during our ack cycle; never take it twice.
    assign rd_take  = bus.ram_rd_ready && !bus.ram_rd_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            buf_valid       <= 1'b0;
            buf_tag         <= '0;
            buf_data        <= '0;
            rmw             <= 1'b0;
            req_lane        <= 1'b0;
            req_byte        <= '0;
            gap             <= '0;
            tmo             <= '0;
            stale           <= '0;
            bus.cpu_rdata   <= '0;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_err     <= 1'b0;
            bus.cpu_busy    <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wr_data <= '0;
            bus.ram_wr_en   <= 1'b0;
            bus.ram_rd_en   <= 1'b0;
            bus.ram_rd_ack  <= 1'b0;
        end else begin
            bus.cpu_ack    <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.ram_wr_en  <= 1'b0;
            bus.ram_rd_en  <= 1'b0;
            bus.ram_rd_ack <= 1'b0;
            if (gap != '0) gap <= gap - 1'b1;

            case (state)
                ST_IDLE: begin
                    if (stale != '0) begin
                        bus.cpu_busy <= 1'b1;
                        if (rd_take) begin
                            bus.ram_rd_ack <= 1'b1;
                            stale          <= stale - 1'b1;
                            if (stale == 2'd1) bus.cpu_busy <= 1'b0;
                        end
                    end else if (bus.cpu_req) begin
                        req_lane <= bus.cpu_addr[0];
                        req_byte <= bus.cpu_wdata;
                        if (!bus.cpu_we && hit) begin
                            bus.cpu_ack   <= 1'b1;
                            bus.cpu_rdata <= pick_byte(buf_data, bus.cpu_addr[0]);
                        end else if (bus.cpu_we && hit) begin
                            buf_data     <= merge_byte(buf_data, bus.cpu_wdata, bus.cpu_addr[0]);
                            bus.ram_addr <= cpu_word;
                            bus.cpu_busy <= 1'b1;
                            state        <= ST_WR_ISSUE;
                        end else begin
                            rmw          <= bus.cpu_we;
                            bus.ram_addr <= cpu_word;
                            bus.cpu_busy <= 1'b1;
                            state        <= ST_RD_ISSUE;
                        end
                    end
                end

                ST_RD_ISSUE: begin
                    // Reads wait out the write gap so the read FIFO cannot overtake a pending write.
                    if (!bus.ram_busy && gap == '0) begin
                        bus.ram_rd_en <= 1'b1;
                        tmo           <= '0;
                        state         <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (rd_take) begin
                        bus.ram_rd_ack <= 1'b1;
                        buf_valid      <= 1'b1;
                        buf_tag        <= bus.ram_addr;
                        if (rmw) begin
                            buf_data <= merge_byte(bus.ram_rd_data, req_byte, req_lane);
                            rmw      <= 1'b0;
                            state    <= ST_WR_ISSUE;
                        end else begin
                            buf_data      <= bus.ram_rd_data;
                            bus.cpu_ack   <= 1'b1;
                            bus.cpu_rdata <= pick_byte(bus.ram_rd_data, req_lane);
                            bus.cpu_busy  <= 1'b0;
                            state         <= ST_IDLE;
                        end
                    end else if (tmo >= TO_W'(TIMEOUT - 1)) begin
                        // The late word will still arrive; count it so IDLE can discard it.
                        bus.cpu_ack   <= 1'b1;
                        bus.cpu_err   <= 1'b1;
                        bus.cpu_rdata <= '0;
                        buf_valid     <= 1'b0;
                        rmw           <= 1'b0;
                        if (stale != 2'd3) stale <= stale + 1'b1;
                        bus.cpu_busy  <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                ST_WR_ISSUE: begin
                    if (!bus.ram_busy) begin
                        bus.ram_wr_en   <= 1'b1;
                        bus.ram_wr_data <= buf_data;
                        gap             <= GAP_W'(WR_GAP);
                        bus.cpu_ack     <= 1'b1;
                        bus.cpu_busy    <= (stale != '0);
                        state           <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_byte_bridge.sv
// tb/tb_sdram_byte_bridge.sv - table and scoreboard bench for sdram_byte_bridge
module tb_sdram_byte_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sdram_byte_bridge_if #(.ADDR_W(24)) bus();

    sdram_byte_bridge #(.ADDR_W(24), .WR_GAP(16), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       chk;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_miss;
    } vec_t;

    exp_t        sb[$];
    rsp_t        pend[$];
    logic [15:0] mem[int];
    exp_t        e_pop;
    rsp_t        r_new;

    int  cyc = 0;
    int  n_rd = 0, n_wr = 0, n_rdack = 0;
    time t_rd = 0, t_wr = 0, t_ack = 0;
    logic [23:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    int   resp_delay = 3;
    logic busy_force = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SDRAM-side model plus cpu_ack scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pend.delete();
        end else begin
            if (bus.ram_rd_ack) begin
                n_rdack++;
                if (pend.size() > 0) pend.delete(0);
            end
            if (bus.ram_rd_en) begin
                n_rd++;
                t_rd = $time;
                r_new.data = mem.exists(int'(bus.ram_addr)) ? mem[int'(bus.ram_addr)] : 16'h0000;
                r_new.due  = cyc + resp_delay;
                pend.push_back(r_new);
            end
            if (bus.ram_wr_en) begin
                n_wr++;
                t_wr = $time;
                last_wr_addr = bus.ram_addr;
                last_wr_data = bus.ram_wr_data;
                mem[int'(bus.ram_addr)] = bus.ram_wr_data;
            end
            if (bus.cpu_ack) begin
                t_ack = $time;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected cpu_ack: got ack with empty scoreboard");
                end else begin
                    e_pop = sb.pop_front();
                    check("ack cpu_err", 64'(bus.cpu_err), 64'(e_pop.err));
                    if (e_pop.chk) check("ack cpu_rdata", 64'(bus.cpu_rdata), 64'(e_pop.rdata));
                end
            end
        end
        bus.ram_busy     = busy_force;
        bus.ram_rd_ready = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.ram_rd_data  = bus.ram_rd_ready ? pend[0].data : 16'h0000;
    end

    time t_start;

    task automatic start_access(input logic we, input logic [24:0] addr, input logic [7:0] wd,
                                input logic [7:0] ed, input logic eerr);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while ((bus.cpu_busy || bus.cpu_ack) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL busy wait: cpu_busy still 1 after %0d cycles, required 0", n);
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        e.rdata = ed;
        e.err   = eerr;
        e.chk   = !we;
        sb.push_back(e);
        t_start = $time;
        @(negedge clk);
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ack wait: no cpu_ack after %0d cycles, required one", n);
            sb.delete();
        end
        lat = int'((t_ack - t_start) / 10);
    endtask

    task automatic access(input logic we, input logic [24:0] addr, input logic [7:0] wd,
                          input logic [7:0] ed, input logic eerr, output int lat);
        start_access(we, addr, wd, ed, eerr);
        wait_done(lat);
    endtask

    vec_t vecs[11];
    int   lat;
    int   n0;
    int   nw;

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        mem[32'h08] = 16'h3C5A;
        mem[32'h10] = 16'h1234;
        mem[32'h18] = 16'hBEEF;
        mem[32'h00] = 16'hA55A;
        mem[32'h0C] = 16'h0102;
        mem[32'h20] = 16'hCAFE;
        mem[32'h28] = 16'h9988;
        mem[32'h30] = 16'h4321;
        mem[32'h38] = 16'h5566;

        vecs[0]  = '{1'b0, 25'h11, 8'h00, 8'h3C, 1'b1};
        vecs[1]  = '{1'b0, 25'h10, 8'h00, 8'h5A, 1'b0};
        vecs[2]  = '{1'b1, 25'h21, 8'hEE, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 25'h20, 8'h00, 8'h34, 1'b0};
        vecs[4]  = '{1'b0, 25'h21, 8'h00, 8'hEE, 1'b0};
        vecs[5]  = '{1'b0, 25'h31, 8'h00, 8'hBE, 1'b1};
        vecs[6]  = '{1'b1, 25'h30, 8'h77, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 25'h30, 8'h00, 8'h77, 1'b0};
        vecs[8]  = '{1'b0, 25'h00, 8'h00, 8'h5A, 1'b1};
        vecs[9]  = '{1'b0, 25'h19, 8'h00, 8'h01, 1'b1};
        vecs[10] = '{1'b1, 25'h18, 8'hAB, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        check("reset outputs", {bus.cpu_rdata, bus.cpu_ack, bus.cpu_err, bus.cpu_busy, bus.ram_addr,
                                bus.ram_wr_data, bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_ack}, 64'h0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            n0 = n_rd;
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0, lat);
            check($sformatf("vec%0d rd_en count", i), 64'(n_rd - n0), 64'(vecs[i].exp_miss));
            if (!vecs[i].exp_miss)
                check($sformatf("vec%0d hit latency", i), 64'(lat), vecs[i].we ? 64'd2 : 64'd1);
        end
        check("rmw word 0x10", 64'(mem[32'h10]), 64'hEE34);
        check("write hit word 0x18", 64'(mem[32'h18]), 64'hBE77);
        check("last wr data", 64'(last_wr_data), 64'h01AB);
        check("last wr addr", 64'(last_wr_addr), 64'h0C);

        // A read right behind a write must hold off for the write gap.
        n0 = n_rd;
        access(1'b0, 25'h41, 8'h00, 8'hCA, 1'b0, lat);
        check("gap read issued", 64'(n_rd - n0), 64'd1);
        check("write->read gap >= 16", 64'((t_rd - t_wr) / 10 >= 16), 64'd1);

        busy_force = 1'b1;
        n0 = n_rd;
        start_access(1'b0, 25'h51, 8'h00, 8'h99, 1'b0);
        repeat (10) @(negedge clk);
        check("no rd_en while ram_busy", 64'(n_rd - n0), 64'd0);
        busy_force = 1'b0;
        wait_done(lat);
        check("one rd_en after ram_busy", 64'(n_rd - n0), 64'd1);

        resp_delay = 300;
        access(1'b0, 25'h61, 8'h00, 8'h00, 1'b1, lat);
        check("timeout latency 255..256", 64'(((t_ack - t_rd) / 10 >= 255) && ((t_ack - t_rd) / 10 <= 256)), 64'd1);
        resp_delay = 3;
        n0 = n_rd;
        nw = n_rdack;
        access(1'b0, 25'h60, 8'h00, 8'h21, 1'b0, lat);
        check("read after timeout is miss", 64'(n_rd - n0), 64'd1);
        check("stale word popped", 64'(n_rdack - nw), 64'd2);

        resp_delay = 20;
        n0 = n_rd;
        start_access(1'b0, 25'h71, 8'h00, 8'h55, 1'b0);
        for (int k = 0; k < 100 && n_rd == n0; k++) @(negedge clk);
        check("rd_en before reset", 64'(n_rd - n0), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("outputs under reset", {bus.cpu_rdata, bus.cpu_ack, bus.cpu_err, bus.cpu_busy, bus.ram_addr,
                                      bus.ram_wr_data, bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_ack}, 64'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        resp_delay = 3;
        n0 = n_rd;
        access(1'b0, 25'h61, 8'h00, 8'h43, 1'b0, lat);
        check("read after reset is miss", 64'(n_rd - n0), 64'd1);

        repeat (5) @(negedge clk);
        check("read fifo drained", 64'(pend.size()), 64'd0);
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
